// File: rtl/icache_sa_if.sv
// Handshake bundle of the instruction cache: fetcher request/response, refill
// request/data, and the reorder-buffer prediction verdict.
interface icache_sa_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 2
);
  localparam int BLOCK_SIZE = 1 << BLOCK_WIDTH;

  logic                    IFIC_en;
  logic [ADDR_WIDTH-1:0]   IFIC_addr;
  logic                    ICIF_en;
  logic [31:0]             ICIF_data;
  logic                    ICMC_en;
  logic [ADDR_WIDTH-1:0]   ICMC_addr;
  logic                    MCIC_en;
  logic [32*BLOCK_SIZE-1:0] MCIC_block;
  logic                    RoBIC_pre_judge;

  // Environment side: fetcher, memory controller and reorder buffer.
  modport master (
    output IFIC_en, IFIC_addr, MCIC_en, MCIC_block, RoBIC_pre_judge,
    input  ICIF_en, ICIF_data, ICMC_en, ICMC_addr
  );

  // Cache side.
  modport slave (
    input  IFIC_en, IFIC_addr, MCIC_en, MCIC_block, RoBIC_pre_judge,
    output ICIF_en, ICIF_data, ICMC_en, ICMC_addr
  );
endinterface

// File: rtl/icache_sa.sv
// Set-associative (1 or 2 way, LRU) instruction cache between fetcher and memory
// controller: registered 1-cycle hits, level-held refill, misprediction squash.
module icache_sa #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 2,
  parameter int SET_WIDTH   = 6,
  parameter int WAYS        = 2
) (
  input  logic         Sys_clk,
  input  logic         Sys_rst_n,
  input  logic         Sys_rdy,
  icache_sa_if.slave   bus
);

  localparam int BLOCK_SIZE = 1 << BLOCK_WIDTH;
  localparam int TAG_LO     = BLOCK_WIDTH + 2 + SET_WIDTH;
  localparam int SETS       = 1 << SET_WIDTH;
  localparam int TAG_W      = ADDR_WIDTH - TAG_LO;
  localparam int OFF_W      = (BLOCK_WIDTH > 0) ? BLOCK_WIDTH : 1;

  if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
    $error("icache_sa: WAYS must be 1 or 2");
  end
  if (BLOCK_WIDTH < 0 || BLOCK_WIDTH > 4) begin : g_bad_block
    $error("icache_sa: BLOCK_WIDTH must be in 0..4");
  end

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
  typedef logic [SET_WIDTH-1:0] set_t;
  typedef logic [TAG_W-1:0]     tag_t;
  typedef logic [OFF_W-1:0]     off_t;
  typedef logic                 way_t;

  // Storage: data/tag arrays carry no reset, valid/LRU do.
  logic [31:0]       data_mem [SETS][WAYS][BLOCK_SIZE];
  tag_t              tag_mem  [SETS][WAYS];
  logic [WAYS-1:0]   valid_q  [SETS];
  logic [SETS-1:0]   lru_q;

  state_t            state_q, state_d;
  logic              discard_q;
  logic              icif_en_q;
  logic [31:0]       icif_data_q;
  logic              icmc_en_q;
  logic [ADDR_WIDTH-1:0] icmc_addr_q;
  set_t              fill_set_q;
  tag_t              fill_tag_q;
  off_t              fill_off_q;

  // Request decode.
  set_t        req_set;
  tag_t        req_tag;
  off_t        req_off;
  logic        hit;
  way_t        hit_way;
  logic [31:0] hit_word;
  way_t        victim;
  logic [31:0] fill_word;

  assign req_off = OFF_W'((bus.IFIC_addr >> 2) & ADDR_WIDTH'(BLOCK_SIZE - 1));
  assign req_set = SET_WIDTH'(bus.IFIC_addr >> (BLOCK_WIDTH + 2));
  assign req_tag = TAG_W'(bus.IFIC_addr >> TAG_LO);

  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_set][w] && tag_mem[req_set][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = w[0];
      end
    end
  end

  assign hit_word = data_mem[req_set][hit_way][req_off];

  // Lowest-index invalid way wins; otherwise evict the LRU way.
  always_comb begin
    victim = (WAYS == 1) ? 1'b0 : lru_q[fill_set_q];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[fill_set_q][w]) victim = w[0];
    end
  end

  // The response word on a fill bypasses the array.
  assign fill_word = bus.MCIC_block[32*int'(fill_off_q) +: 32];

  // Control decode.
  logic hit_resp, miss_go, fill_go;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    hit_resp = 1'b0;
    miss_go  = 1'b0;
    fill_go  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // icif_en_q high marks the fetcher's update bubble.
        if (Sys_rdy && bus.IFIC_en && !icif_en_q) begin
          if (hit) begin
            hit_resp = bus.RoBIC_pre_judge;
          end else begin
            miss_go = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.MCIC_en) begin
          fill_go = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      lru_q       <= '0;
      discard_q   <= 1'b0;
      icif_en_q   <= 1'b0;
      icif_data_q <= '0;
      icmc_en_q   <= 1'b0;
      icmc_addr_q <= '0;
      fill_set_q  <= '0;
      fill_tag_q  <= '0;
      fill_off_q  <= '0;
    end else begin
      icif_en_q <= 1'b0;
      if (hit_resp) begin
        icif_en_q      <= 1'b1;
        icif_data_q    <= hit_word;
        lru_q[req_set] <= ~hit_way;
      end
      if (miss_go) begin
        icmc_en_q   <= 1'b1;
        icmc_addr_q <= bus.IFIC_addr & ~ADDR_WIDTH'(4*BLOCK_SIZE - 1);
        fill_set_q  <= req_set;
        fill_tag_q  <= req_tag;
        fill_off_q  <= req_off;
        discard_q   <= !bus.RoBIC_pre_judge;
      end
      if (state_q == ST_WAIT && !bus.RoBIC_pre_judge) discard_q <= 1'b1;
      if (fill_go) begin
        icmc_en_q                   <= 1'b0;
        valid_q[fill_set_q][victim] <= 1'b1;
        lru_q[fill_set_q]           <= ~victim;
        discard_q                   <= 1'b0;
        if (!discard_q && bus.RoBIC_pre_judge) begin
          icif_en_q   <= 1'b1;
          icif_data_q <= fill_word;
        end
      end
    end
  end

  // NOTE: the arrays are deliberately left out of reset; valid bits alone qualify their contents.
  always_ff @(posedge Sys_clk) begin
    if (fill_go) begin
      tag_mem[fill_set_q][victim] <= fill_tag_q;
      for (int k = 0; k < BLOCK_SIZE; k++) begin
        data_mem[fill_set_q][victim][k] <= bus.MCIC_block[32*k +: 32];
      end
    end
  end

  assign bus.ICIF_en   = icif_en_q;
  assign bus.ICIF_data = icif_data_q;
  assign bus.ICMC_en   = icmc_en_q;
  assign bus.ICMC_addr = icmc_addr_q;

  a_refill_held: assert property (@(posedge Sys_clk) disable iff (!Sys_rst_n)
    (state_q == ST_WAIT && !bus.MCIC_en) |=> (icmc_en_q && $stable(icmc_addr_q)));

  a_resp_pulse: assert property (@(posedge Sys_clk) disable iff (!Sys_rst_n)
    icif_en_q |=> !icif_en_q);

endmodule

// File: tb/tb_icache_sa.sv
// Randomized and directed bench for icache_sa against a recency-ordered residency
// model of the cache and a synthetic instruction memory.
module tb_icache_sa;

  localparam int AW     = 32;
  localparam int BW     = 2;
  localparam int SW     = 6;
  localparam int WAYS   = 2;
  localparam int BS     = 1 << BW;
  localparam int SETS   = 1 << SW;
  localparam int TAG_LO = BW + 2 + SW;

  logic Sys_clk = 1'b0;
  logic Sys_rst_n;
  logic Sys_rdy;

  icache_sa_if #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) bus ();

  icache_sa #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .SET_WIDTH(SW), .WAYS(WAYS)) dut (
    .Sys_clk   (Sys_clk),
    .Sys_rst_n (Sys_rst_n),
    .Sys_rdy   (Sys_rdy),
    .bus       (bus)
  );

  always #5 Sys_clk = ~Sys_clk;

  int checks = 0;
  int errors = 0;

  // Model: resident block numbers mapped to their last-use time.
  longint stamp [logic [31:0]];
  longint now_t = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w = a >> 2;
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ {w[15:0], w[31:16]};
  endfunction

  function automatic logic [32*BS-1:0] mem_block(input logic [31:0] a);
    logic [32*BS-1:0] b;
    logic [31:0] base = a & ~32'(BS*4 - 1);
    for (int k = 0; k < BS; k++) b[32*k +: 32] = mem_word(base + 32'(4*k));
    return b;
  endfunction

  function automatic logic [31:0] blk_of(input logic [31:0] a);
    return a >> (BW + 2);
  endfunction

  function automatic void model_fill(input logic [31:0] blk);
    int n = 0;
    logic [31:0] oldest_blk = '0;
    longint oldest = 0;
    foreach (stamp[k]) begin
      if ((k % SETS) == (blk % SETS)) begin
        n++;
        if (n == 1 || stamp[k] < oldest) begin
          oldest     = stamp[k];
          oldest_blk = k;
        end
      end
    end
    if (n >= WAYS) stamp.delete(oldest_blk);
    stamp[blk] = now_t++;
  endfunction

  task automatic tick();
    @(posedge Sys_clk);
    #1;
  endtask

  task automatic reset_dut();
    Sys_rst_n = 1'b0;
    tick();
    Sys_rst_n = 1'b1;
    stamp.delete();
    tick();
  endtask

  // One complete fetch transaction; exp_hit < 0 takes the hit/miss decision from the model.
  task automatic fetch(input logic [31:0] addr, input int exp_hit, input bit sq_lookup,
                       input int sq_wait, input int mc_delay, input bit rdy_low_fill);
    logic [31:0] blk     = blk_of(addr);
    logic [31:0] aligned = addr & ~32'(BS*4 - 1);
    bit          hit     = (exp_hit < 0) ? stamp.exists(blk) : (exp_hit != 0);
    bit          discard = sq_lookup;
    bus.IFIC_en         = 1'b1;
    bus.IFIC_addr       = addr;
    bus.RoBIC_pre_judge = !sq_lookup;
    tick();
    bus.RoBIC_pre_judge = 1'b1;
    if (hit) begin
      checks++;
      if (bus.ICIF_en !== !sq_lookup || bus.ICMC_en !== 1'b0) begin
        errors++;
        $display("FAIL hit_resp addr=%h: icif_en=%b icmc_en=%b, want %b/0",
                 addr, bus.ICIF_en, bus.ICMC_en, !sq_lookup);
      end
      if (!sq_lookup) begin
        checks++;
        if (bus.ICIF_data !== mem_word(addr)) begin
          errors++;
          $display("FAIL hit_data addr=%h: got %h, want %h", addr, bus.ICIF_data, mem_word(addr));
        end
        stamp[blk] = now_t++;
      end
    end else begin
      checks++;
      if (bus.ICMC_en !== 1'b1 || bus.ICMC_addr !== aligned || bus.ICIF_en !== 1'b0) begin
        errors++;
        $display("FAIL miss_req addr=%h: icmc_en=%b icmc_addr=%h icif_en=%b, want 1/%h/0",
                 addr, bus.ICMC_en, bus.ICMC_addr, bus.ICIF_en, aligned);
      end
      for (int d = 0; d < mc_delay; d++) begin
        bus.IFIC_addr       = $urandom;
        bus.RoBIC_pre_judge = (d != sq_wait);
        if (d == sq_wait) discard = 1'b1;
        tick();
        checks++;
        if (bus.ICMC_en !== 1'b1 || bus.ICMC_addr !== aligned || bus.ICIF_en !== 1'b0) begin
          errors++;
          $display("FAIL wait_hold addr=%h cyc=%0d: icmc_en=%b icmc_addr=%h icif_en=%b, want 1/%h/0",
                   addr, d, bus.ICMC_en, bus.ICMC_addr, bus.ICIF_en, aligned);
        end
      end
      bus.RoBIC_pre_judge = 1'b1;
      bus.MCIC_en         = 1'b1;
      bus.MCIC_block      = mem_block(addr);
      if (rdy_low_fill) Sys_rdy = 1'b0;
      tick();
      bus.MCIC_en    = 1'b0;
      bus.MCIC_block = {BS{32'($urandom)}};
      Sys_rdy        = 1'b1;
      model_fill(blk);
      checks++;
      if (bus.ICMC_en !== 1'b0 || bus.ICIF_en !== !discard) begin
        errors++;
        $display("FAIL fill_resp addr=%h: icmc_en=%b icif_en=%b, want 0/%b",
                 addr, bus.ICMC_en, bus.ICIF_en, !discard);
      end
      if (!discard) begin
        checks++;
        if (bus.ICIF_data !== mem_word(addr)) begin
          errors++;
          $display("FAIL fill_data addr=%h: got %h, want %h", addr, bus.ICIF_data, mem_word(addr));
        end
      end
    end
    bus.IFIC_en = 1'b0;
    tick();
    checks++;
    if (bus.ICIF_en !== 1'b0) begin
      errors++;
      $display("FAIL resp_pulse addr=%h: icif_en=%b, want 0", addr, bus.ICIF_en);
    end
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if (bus.ICIF_en !== 1'b0 || bus.ICIF_data !== 32'h0 || bus.ICMC_en !== 1'b0 || bus.ICMC_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_vals: icif_en=%b icif_data=%h icmc_en=%b icmc_addr=%h, want all 0",
               bus.ICIF_en, bus.ICIF_data, bus.ICMC_en, bus.ICMC_addr);
    end
    Sys_rst_n = 1'b1;
    tick();
    bus.IFIC_en   = 1'b1;
    bus.IFIC_addr = 32'h0000_5010;
    tick();
    checks++;
    if (bus.ICMC_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_miss: icmc_en=%b, want 1", bus.ICMC_en);
    end
    tick();
    #2 Sys_rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ICMC_en !== 1'b0 || bus.ICIF_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: icmc_en=%b icif_en=%b, want 0/0", bus.ICMC_en, bus.ICIF_en);
    end
    bus.IFIC_en = 1'b0;
    stamp.delete();
    tick();
    Sys_rst_n = 1'b1;
    tick();
    bus.MCIC_en    = 1'b1;
    bus.MCIC_block = mem_block(32'h0000_5010);
    tick();
    bus.MCIC_en = 1'b0;
    checks++;
    if (bus.ICIF_en !== 1'b0 || bus.ICMC_en !== 1'b0) begin
      errors++;
      $display("FAIL stray_fill: icif_en=%b icmc_en=%b, want 0/0", bus.ICIF_en, bus.ICMC_en);
    end
    fetch(32'h0000_5010, 0, 1'b0, -1, 1, 1'b0);
  endtask

  task automatic test_cold_miss();
    fetch(32'h0000_1008, 0, 1'b0, -1, 3, 1'b0);
    fetch(32'h0000_100C, 1, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_lru();
    reset_dut();
    fetch(32'h0000_0000, 0, 1'b0, -1, 1, 1'b0);
    fetch(32'h0000_0400, 0, 1'b0, -1, 1, 1'b0);
    fetch(32'h0000_0000, 1, 1'b0, -1, 0, 1'b0);
    fetch(32'h0000_0800, 0, 1'b0, -1, 2, 1'b0);
    fetch(32'h0000_0004, 1, 1'b0, -1, 0, 1'b0);
    fetch(32'h0000_0408, 0, 1'b0, -1, 1, 1'b0);
  endtask

  task automatic test_wait_squash();
    fetch(32'h0000_6004, 0, 1'b0, 0, 2, 1'b0);
    fetch(32'h0000_6008, 1, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_hit_squash();
    fetch(32'h0000_1040, 0, 1'b0, -1, 1, 1'b0);
    fetch(32'h0000_1044, 1, 1'b1, -1, 0, 1'b0);
    fetch(32'h0000_1048, 1, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_rdy();
    fetch(32'h0000_2050, 0, 1'b0, -1, 1, 1'b0);
    Sys_rdy       = 1'b0;
    bus.IFIC_en   = 1'b1;
    bus.IFIC_addr = 32'h0000_2054;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.ICIF_en !== 1'b0) begin
        errors++;
        $display("FAIL rdy_hold cyc=%0d: icif_en=%b, want 0", i, bus.ICIF_en);
      end
    end
    Sys_rdy = 1'b1;
    tick();
    bus.IFIC_en = 1'b0;
    checks++;
    if (bus.ICIF_en !== 1'b1 || bus.ICIF_data !== mem_word(32'h0000_2054)) begin
      errors++;
      $display("FAIL rdy_resume: icif_en=%b data=%h, want 1/%h",
               bus.ICIF_en, bus.ICIF_data, mem_word(32'h0000_2054));
    end
    stamp[blk_of(32'h0000_2054)] = now_t++;
    tick();
    checks++;
    if (bus.ICIF_en !== 1'b0) begin
      errors++;
      $display("FAIL rdy_pulse: icif_en=%b, want 0", bus.ICIF_en);
    end
    fetch(32'h0000_3068, 0, 1'b0, -1, 2, 1'b1);
    fetch(32'h0000_306C, 1, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_bubble();
    bus.IFIC_en   = 1'b1;
    bus.IFIC_addr = 32'h0000_2058;
    tick();
    checks++;
    if (bus.ICIF_en !== 1'b1) begin
      errors++;
      $display("FAIL bubble_first: icif_en=%b, want 1", bus.ICIF_en);
    end
    tick();
    checks++;
    if (bus.ICIF_en !== 1'b0) begin
      errors++;
      $display("FAIL bubble_gap: icif_en=%b, want 0", bus.ICIF_en);
    end
    tick();
    bus.IFIC_en = 1'b0;
    checks++;
    if (bus.ICIF_en !== 1'b1 || bus.ICIF_data !== mem_word(32'h0000_2058)) begin
      errors++;
      $display("FAIL bubble_again: icif_en=%b data=%h, want 1/%h",
               bus.ICIF_en, bus.ICIF_data, mem_word(32'h0000_2058));
    end
    stamp[blk_of(32'h0000_2058)] = now_t++;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      int          sq_w;
      a = (32'($urandom_range(0, 3)) << TAG_LO) | (32'($urandom_range(0, 3)) << (BW + 2))
        | (32'($urandom_range(0, BS - 1)) << 2) | 32'($urandom_range(0, 3));
      sq_w = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : -1;
      fetch(a, -1, ($urandom_range(0, 7) == 0), sq_w, int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    Sys_rst_n           = 1'b0;
    Sys_rdy             = 1'b1;
    bus.IFIC_en         = 1'b0;
    bus.IFIC_addr       = '0;
    bus.MCIC_en         = 1'b0;
    bus.MCIC_block      = '0;
    bus.RoBIC_pre_judge = 1'b1;
    test_reset();
    test_cold_miss();
    test_lru();
    test_wait_squash();
    test_hit_squash();
    test_rdy();
    test_bubble();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Parametrised successor instruction cache between the instruction fetcher (IF) and the memory controller (MC).
- Set-associative with 1 or 2 ways, LRU replacement and arbitrary block length.
- Registered 1-cycle hit response, miss refill through a level-held MC request, and squash of in-flight responses on a RoB misprediction.
- Generic offset selection: no hard-coded 2-word blocks.

Parameters:
- ADDR_WIDTH, 32, address width in bits.
- BLOCK_WIDTH, 2, log2 of instructions (32-bit words) per block; legal range 0..4.
- SET_WIDTH, 6, log2 of the number of sets.
- WAYS, 2, associativity; legal values 1 or 2 (elaboration error otherwise).
- Derived, not overridable: BLOCK_SIZE = 1<<BLOCK_WIDTH; TAG_LO = BLOCK_WIDTH+2+SET_WIDTH.

Ports:
- Sys_clk  in  1  clock; all state updates on the rising edge.
- Sys_rst_n  in  1  asynchronous, active-low reset.
- Sys_rdy  in  1  global enable; 0 freezes the lookup/response logic.
- IFIC_en  in  1  fetch request; held high by IF until ICIF_en is seen.
- IFIC_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
- ICIF_en  out  1  one-cycle response valid.
- ICIF_data  out  32  instruction word.
- ICMC_en  out  1  refill request, level-held until MCIC_en.
- ICMC_addr  out  ADDR_WIDTH  block-aligned refill address.
- MCIC_en  in  1  one-cycle refill-data-valid pulse.
- MCIC_block  in  32*BLOCK_SIZE  refill block; word k in bits [32k+31:32k].
- RoBIC_pre_judge  in  1  1 = prediction correct; 0 = misprediction, squash the current fetch.

Behaviour:
- Address fields: offset = addr[BLOCK_WIDTH+1:2]; set = addr[TAG_LO-1:BLOCK_WIDTH+2]; tag = addr[ADDR_WIDTH-1:TAG_LO].
- Reset (Sys_rst_n=0, asynchronous):
  - All valid bits = 0, LRU bits = 0, state = IDLE, discard = 0.
  - ICIF_en = 0, ICIF_data = 0, ICMC_en = 0, ICMC_addr = 0.
  - Data and tag arrays are not reset.
  - Reset mid-refill abandons the refill; a later MCIC_en pulse while IDLE with ICMC_en=0 is ignored.
- States: IDLE, WAIT.
- ICIF_en is a single-cycle pulse. In the cycle after an ICIF_en pulse, IFIC_en is ignored (IF update bubble).
- IDLE, IFIC_en=1, Sys_rdy=1, not bubble:
  - Hit (valid and tag match in any way): at the next edge ICIF_en=1 and ICIF_data = data[set][way][offset]; the set's LRU points to the other way.
  - Hit with RoBIC_pre_judge=0 in the same cycle: no response, no LRU update.
  - Miss: next edge state=WAIT, ICMC_en=1, ICMC_addr = IFIC_addr with bits [BLOCK_WIDTH+1:0] cleared. Offset and set are latched internally.
  - Miss with RoBIC_pre_judge=0 in the same cycle: the refill still issues, with discard=1.
- WAIT:
  - ICMC_en and ICMC_addr stay constant until MCIC_en.
  - RoBIC_pre_judge=0 in any WAIT cycle sets discard=1. IFIC_en changes are ignored.
- Fill (MCIC_en=1 while in WAIT):
  - Processed regardless of Sys_rdy, because the pulse is not repeated.
  - Victim: the lowest-index invalid way; otherwise the LRU way (WAYS=1: way 0).
  - Write the victim's valid bit, tag and all BLOCK_SIZE words; LRU points away from the victim.
  - ICMC_en=0 at the same edge; state=IDLE.
  - If discard=0 and RoBIC_pre_judge=1: ICIF_en=1 with the latched offset's word taken from MCIC_block, not the array.
  - Otherwise: no response, discard cleared to 0.
- MCIC_en in IDLE: ignored; arrays unchanged.
- Sys_rdy=0: state, outputs and arrays hold, except the fill path above. A pending ICIF_en still drops after one cycle.
- A fill and a new request never overlap, since IF is blocked in WAIT. There is no write port from IF.

Test Plan:
- Reset: Sys_rst_n low mid-WAIT -> ICMC_en=0 and ICIF_en=0 asynchronously; the first fetch afterwards of any address misses.
- Cold miss: IFIC_addr=0x0000_1008 (BLOCK_WIDTH=2) -> ICMC_addr=0x0000_1000 held until MCIC_en with block {w3,w2,w1,w0}=4 distinct words -> ICIF_data=w2 one edge later; refetch of 0x100C hits with 1-cycle latency and returns w3.
- 2-way LRU (SET_WIDTH=6, BLOCK_WIDTH=2): fill 0x0000, fill 0x0400 (same set), hit 0x0000, fill 0x0800 -> the 0x0400 line is evicted; 0x0000 still hits, 0x0400 misses.
- Misprediction in WAIT: RoBIC_pre_judge=0 for 1 cycle before MCIC_en -> no ICIF_en pulse; line installed; the next fetch of the same block hits.
- Hit squash: RoBIC_pre_judge=0 in the cycle of a hit lookup -> ICIF_en stays 0; the following request is serviced normally.
- Sys_rdy=0 for 3 cycles with IFIC_en=1 on a hit address -> no response until Sys_rdy=1, then ICIF_en exactly 1 cycle; MCIC_en arriving while Sys_rdy=0 still fills and responds.
